// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
// Pure declarations: no logic, no latency, no flow control of its own.
package mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel arbiter: fixed priority from 0 or round-robin from ptr; a lock overrides the search.
// Zero latency; grant is offered regardless of downstream readiness, the caller qualifies it.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int MODE = MODE_RR,
   localparam int SELW = sel_width(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   input  logic            lock,
   input  logic [SELW-1:0] lock_idx,
   output logic [NCH-1:0]  grant,
   output logic [SELW-1:0] grant_idx
);

   function automatic int wrap(input int a);
      return (a >= NCH) ? a - NCH : a;
   endfunction

   logic found;
   int   start;

   assign start = (MODE == MODE_RR) ? int'(ptr) : 0;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      if (lock) begin
         // A held packet owns the output even while its producer is idle.
         grant_idx = lock_idx;
         for (int i = 0; i < NCH; i++) begin
            if (lock_idx == SELW'(i)) grant[i] = 1'b1;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (!found && req[wrap(start + k)]) begin
               found                 = 1'b1;
               grant[wrap(start + k)] = 1'b1;
               grant_idx             = SELW'(wrap(start + k));
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with arbitration, packet lock and a one-entry output register.
// One cycle accept-to-out_valid; all in_ready drop while the held beat is stalled by out_ready=0.
module stream_mux_arb
   import mux_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int W    = 8,
   parameter int MODE = MODE_RR,
   localparam int SELW = sel_width(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    in_valid,
   input  logic [NCH*W-1:0]  in_data,
   input  logic [NCH-1:0]    in_last,
   output logic [NCH-1:0]    in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic              out_last,
   output logic [SELW-1:0]   out_sel,
   input  logic              out_ready
);

   lock_state_t     lock_st, lock_nxt;
   logic [SELW-1:0] lock_idx;
   logic [SELW-1:0] ptr;
   logic [NCH-1:0]  grant;
   logic [SELW-1:0] grant_idx;
   logic            load;
   logic            xfer;
   logic [W-1:0]    g_data;
   logic            g_last;

   rr_arbiter #(
      .NCH  (NCH),
      .MODE (MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .lock      (lock_st == LOCKED),
      .lock_idx  (lock_idx),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign load     = rst_n & (~out_valid | out_ready);
   assign in_ready = load ? (grant & in_valid) : '0;
   assign xfer     = |in_ready;

   always_comb begin
      g_data = '0;
      g_last = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            g_data = in_data[i*W +: W];
            g_last = in_last[i];
         end
      end
   end

   always_comb begin
      lock_nxt = lock_st;
      if (xfer) lock_nxt = g_last ? UNLOCKED : LOCKED;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_st   <= UNLOCKED;
         lock_idx  <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
      end else begin
         lock_st <= lock_nxt;
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_last  <= g_last;
            out_sel   <= grant_idx;
            if (!g_last) lock_idx <= grant_idx;
            // Pointer only advances at packet boundaries so a packet's successor starts fresh.
            if (g_last && MODE == MODE_RR)
               ptr <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Drives a fixed-priority and a round-robin instance with identical stimulus,
// checking both against a transaction-level reference model.
module tb_stream_mux_arb;
   import mux_pkg::*;

   localparam int NCH  = 4;
   localparam int W    = 8;
   localparam int SELW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NCH-1:0]   in_valid;
   logic [NCH-1:0]   in_last;
   logic [NCH*W-1:0] in_data;
   logic             out_ready;

   logic [NCH-1:0]   o_rdy  [2];
   logic             o_vld  [2];
   logic [W-1:0]     o_dat  [2];
   logic             o_last [2];
   logic [SELW-1:0]  o_sel  [2];

   // Reference model state: index 0 = fixed priority, 1 = round-robin.
   bit               mv    [2] = '{0, 0};
   logic [W-1:0]     md    [2] = '{0, 0};
   bit               ml    [2] = '{0, 0};
   int               ms    [2] = '{0, 0};
   int               mptr  [2] = '{0, 0};
   int               mlock [2] = '{-1, -1};
   logic [NCH-1:0]   er    [2];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stream_mux_arb #(.NCH(NCH), .W(W), .MODE(MODE_FIXED)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(o_rdy[0]), .out_valid(o_vld[0]), .out_data(o_dat[0]), .out_last(o_last[0]),
      .out_sel(o_sel[0]), .out_ready(out_ready)
   );

   stream_mux_arb #(.NCH(NCH), .W(W), .MODE(MODE_RR)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(o_rdy[1]), .out_valid(o_vld[1]), .out_data(o_dat[1]), .out_last(o_last[1]),
      .out_sel(o_sel[1]), .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int ch, input logic [W-1:0] val);
      in_data[ch*W +: W] = val;
   endtask

   // Which channel may move this cycle, derived from the arbitration rules.
   function automatic logic [NCH-1:0] exp_ready(input int m);
      int   g;
      int   start;
      logic ld;
      logic [NCH-1:0] r;
      g     = -1;
      start = (m == 1) ? mptr[m] : 0;
      if (mlock[m] >= 0) g = mlock[m];
      else begin
         for (int k = 0; k < NCH; k++) begin
            if (g < 0 && in_valid[(start + k) % NCH]) g = (start + k) % NCH;
         end
      end
      ld = rst_n && (!mv[m] || out_ready);
      r  = '0;
      if (ld && g >= 0 && in_valid[g]) r[g] = 1'b1;
      return r;
   endfunction

   task automatic model_edge(input int m);
      int g;
      if (!rst_n) begin
         mv[m] = 0; md[m] = '0; ml[m] = 0; ms[m] = 0; mptr[m] = 0; mlock[m] = -1;
      end else if (er[m] != '0) begin
         g = 0;
         for (int i = 0; i < NCH; i++) if (er[m][i]) g = i;
         mv[m] = 1;
         md[m] = in_data[g*W +: W];
         ml[m] = in_last[g];
         ms[m] = g;
         if (in_last[g]) begin
            mlock[m] = -1;
            if (m == 1) mptr[m] = (g + 1) % NCH;
         end else begin
            mlock[m] = g;
         end
      end else if (mv[m] && out_ready) begin
         mv[m] = 0;
      end
   endtask

   // Entered at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic cycle();
      #1;
      for (int m = 0; m < 2; m++) begin
         er[m] = exp_ready(m);
         check($sformatf("in_ready[m%0d]", m), 32'(o_rdy[m]), 32'(er[m]));
         check($sformatf("onehot[m%0d]", m), 32'($countones(o_rdy[m]) <= 1), 32'd1);
         check($sformatf("out_valid[m%0d]", m), 32'(o_vld[m]), 32'(mv[m]));
         check($sformatf("out_data[m%0d]", m), 32'(o_dat[m]), 32'(md[m]));
         check($sformatf("out_last[m%0d]", m), 32'(o_last[m]), 32'(ml[m]));
         check($sformatf("out_sel[m%0d]", m), 32'(o_sel[m]), 32'(ms[m]));
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) model_edge(m);
      @(negedge clk);
   endtask

   task automatic reset_cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = '1;
      in_last   = '1;
      in_data   = '0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);

      // Reset held with every channel requesting
      for (int k = 0; k < 3; k++) begin
         #1;
         check("rst_in_ready_fp", 32'(o_rdy[0]), 32'h0);
         check("rst_in_ready_rr", 32'(o_rdy[1]), 32'h0);
         cycle();
         check("rst_out_valid", 32'(o_vld[1]), 32'h0);
         check("rst_out_data", 32'(o_dat[1]), 32'h0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < NCH; i++) set_data(i, W'(8'h10 + i));
      #1;
      check("release_ready_fp", 32'(o_rdy[0]), 32'h1);
      check("release_ready_rr", 32'(o_rdy[1]), 32'h1);
      cycle();
      check("release_sel_rr", 32'(o_sel[1]), 32'h0);

      // Round-robin rotation versus fixed priority with all channels busy
      for (int k = 1; k <= 8; k++) begin
         cycle();
         check("rr_seq_sel", 32'(o_sel[1]), 32'(k % NCH));
         check("rr_seq_vld", 32'(o_vld[1]), 32'h1);
         check("fp_seq_sel", 32'(o_sel[0]), 32'h0);
      end

      // Fixed priority: ch1 always beats ch3
      in_valid = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("fp_prio_sel", 32'(o_sel[0]), 32'h1);
      end

      // Packet lock on ch2 with a mid-packet gap
      reset_cycle();
      in_valid = 4'b0100; in_last = 4'b0000; set_data(2, 8'h21);
      cycle();
      check("lock_b1_fp", 32'(o_sel[0]), 32'h2);
      check("lock_b1_rr", 32'(o_sel[1]), 32'h2);
      in_valid = 4'b0101; in_last = 4'b0001; set_data(2, 8'h22);
      cycle();
      check("lock_b2_fp", 32'(o_sel[0]), 32'h2);
      check("lock_b2_rr", 32'(o_sel[1]), 32'h2);
      in_valid = 4'b0001;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("bubble_ready_fp", 32'(o_rdy[0]), 32'h0);
         check("bubble_ready_rr", 32'(o_rdy[1]), 32'h0);
         cycle();
         check("bubble_vld_fp", 32'(o_vld[0]), 32'h0);
      end
      in_valid = 4'b0101; in_last = 4'b0101; set_data(2, 8'h23);
      cycle();
      check("lock_b3_sel", 32'(o_sel[0]), 32'h2);
      check("lock_b3_last", 32'(o_last[0]), 32'h1);
      cycle();
      check("post_lock_fp", 32'(o_sel[0]), 32'h0);
      check("post_lock_rr", 32'(o_sel[1]), 32'h0);

      // Back-pressure with a held 8'hA5 beat
      reset_cycle();
      in_valid = 4'b0001; in_last = 4'b1111; set_data(0, 8'hA5);
      cycle();
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int i = 0; i < NCH; i++) set_data(i, W'(8'h30 + i));
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready_fp", 32'(o_rdy[0]), 32'h0);
         check("bp_ready_rr", 32'(o_rdy[1]), 32'h0);
         cycle();
         check("bp_hold_data", 32'(o_dat[0]), 32'hA5);
         check("bp_hold_vld", 32'(o_vld[0]), 32'h1);
      end
      out_ready = 1'b1;
      #1;
      check("drain_ready_fp", 32'(o_rdy[0]), 32'h1);
      check("drain_ready_rr", 32'(o_rdy[1]), 32'h2);
      cycle();
      check("drain_vld_fp", 32'(o_vld[0]), 32'h1);
      check("drain_data_fp", 32'(o_dat[0]), 32'h30);
      check("drain_data_rr", 32'(o_dat[1]), 32'h31);

      // Reset in the middle of a ch1 packet
      reset_cycle();
      in_valid = 4'b0010; in_last = 4'b0000; set_data(1, 8'h41);
      cycle();
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(o_rdy[1]), 32'h0);
      cycle();
      check("midrst_vld_fp", 32'(o_vld[0]), 32'h0);
      check("midrst_vld_rr", 32'(o_vld[1]), 32'h0);
      rst_n = 1'b1; in_valid = 4'b1000; in_last = 4'b1000; set_data(3, 8'h43);
      #1;
      check("midrst_ch3_fp", 32'(o_rdy[0]), 32'h8);
      check("midrst_ch3_rr", 32'(o_rdy[1]), 32'h8);
      cycle();
      check("midrst_sel3", 32'(o_sel[1]), 32'h3);

      // Randomised traffic against the model
      for (int k = 0; k < 600; k++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         in_valid  = NCH'($urandom);
         in_last   = NCH'($urandom);
         in_data   = (NCH*W)'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
